// File: rtl/nibble_rx.sv
// Receive side of the 4-bit valid/ready nibble link.
// Assembles BEATS beats LSB-first into one word, with an idle timeout.
module nibble_rx #(
  parameter int DATA_W  = 4,
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic                    ready_o,
  output logic                    word_valid_o,
  output logic [DATA_W*BEATS-1:0] word_o,
  input  logic                    word_ready_i,
  output logic                    timeout_o,
  output logic [7:0]              word_cnt_o
);

  localparam int WW = DATA_W * BEATS;
  localparam int CW = $clog2(BEATS);
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [IW-1:0] TO_LAST =
    IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [WW-1:0]   word_q, word_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic            to_q, to_d;
  logic [7:0]      wcnt_q, wcnt_d;
  logic            accept;

  assign accept = valid_i & ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      word_q  <= word_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    word_d  = word_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          word_d[cnt_q*DATA_W +: DATA_W] = data_i;
          cnt_d   = CW'(1);
          idle_d  = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          word_d[cnt_q*DATA_W +: DATA_W] = data_i;
          idle_d = '0;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (TIMEOUT != 0) begin
          // a beat on the deadline cycle wins over the timeout
          if (idle_q == TO_LAST) begin
            cnt_d   = '0;
            idle_d  = '0;
            to_d    = 1'b1;
            state_d = IDLE;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (word_ready_i) begin
          valid_d = 1'b0;
          wcnt_d  = wcnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != HOLD);
  end

  assign ready_o      = ready_q;
  assign word_valid_o = valid_q;
  assign word_o       = word_q;
  assign timeout_o    = to_q;
  assign word_cnt_o   = wcnt_q;

endmodule

// File: doc/nibble_rx.md
Name: nibble_rx

Overview:
- Receiving end of the 4-bit valid/ready nibble link driven by the team's tx-side FSM.
- Accepts BEATS nibbles, LSB-first, and assembles them into one word.
- Presents the word downstream on its own valid/ready handshake.
- Drops a stalled partial word after a configurable idle timeout and flags it.

Parameters:
- DATA_W, 4, width of one received beat (matches the tx data_o width).
- BEATS, 4, beats per assembled word; legal range 2..16.
- TIMEOUT, 8, consecutive idle cycles in COLLECT before the partial word is discarded; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_i  in  1  upstream beat valid.
- data_i  in  DATA_W  upstream beat data; ignored when valid_i=0.
- ready_o  out  1  registered; receiver can accept a beat.
- word_valid_o  out  1  assembled word available.
- word_o  out  DATA_W*BEATS  assembled word; beat 0 sits in the LSBs.
- word_ready_i  in  1  downstream accepts the word.
- timeout_o  out  1  one-cycle pulse; a partial word was discarded.
- word_cnt_o  out  8  count of delivered words; wraps 255->0.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, beat counter=0, idle counter=0, ready_o=0, word_valid_o=0, word_o=0, timeout_o=0, word_cnt_o=0.
  - ready_o rises on the first edge after rst deasserts.
  - rst mid-word or mid-HOLD discards all data; no timeout_o pulse.
- Beat accept = valid_i & ready_o at a rising edge. A beat is stored into slice [cnt*DATA_W +: DATA_W], then cnt increments.
- ready_o is a register with no combinational path from any input. It is 1 in IDLE and COLLECT and 0 in HOLD.
- State IDLE (cnt=0):
  - accept -> store beat 0, cnt=1, go to COLLECT.
  - otherwise stay; idle counter is not running.
- State COLLECT (1 <= cnt <= BEATS-1):
  - accept with cnt<BEATS-1 -> store beat, cnt+1, idle counter=0.
  - accept with cnt=BEATS-1 -> store the last beat, go to HOLD. On that same edge: ready_o<=0, word_valid_o<=1, cnt<=0.
  - no accept -> idle counter+1.
  - If the idle counter reaches TIMEOUT: discard partial data, cnt=0, go to IDLE, timeout_o=1 for exactly one cycle.
  - A beat accepted on the cycle the counter would reach TIMEOUT takes priority. It is stored, and no timeout occurs.
- State HOLD:
  - word_valid_o=1; word_o is held stable.
  - word_ready_i=1 -> go to IDLE on that edge: word_valid_o<=0, ready_o<=1, word_cnt_o+1.
  - word_ready_i=0 -> stay indefinitely; no timeout runs in HOLD.
- Latency:
  - Last beat accepted at edge N -> word_valid_o=1 after edge N.
  - Earliest next beat accept is one cycle after the word handshake; back-to-back throughput is BEATS+1 cycles per word.
- word_o keeps its last value after the handshake. It changes only as new beats are written.
- valid_i may assert or drop at any cycle; gaps between beats are legal up to TIMEOUT-1 cycles.
- word_ready_i is ignored outside HOLD.

Test Plan:
1. Reset, then drive beats 0x1, 0x2, 0x3, 0x4 on consecutive cycles, word_ready_i=1 -> ready_o=1 after reset; word_valid_o=1 one cycle after beat 4 with word_o=0x4321; word_cnt_o=1 after the handshake.
2. Assemble word 0xA5C3, hold word_ready_i=0 for 10 cycles while valid_i=1 -> ready_o=0 and word_o=0xA5C3 stay stable for all 10 cycles; no beat is consumed; word_ready_i=1 -> IDLE, ready_o=1 next cycle.
3. Send beats 0x7, 0x8, then 8 idle cycles (TIMEOUT=8) -> timeout_o pulses for exactly 1 cycle, no word_valid_o; next beats 0x1..0x4 give word_o=0x4321.
4. Send 2 beats, idle 7 cycles, then beat 3 on the 8th cycle, then beat 4 -> no timeout_o; word_valid_o=1 with all four beats assembled correctly.
5. Assert rst after 3 beats, and separately during HOLD -> word_valid_o=0, ready_o=0 while rst is high, no timeout_o; a fresh word 0x1111 then assembles cleanly.
6. Deliver 256 words back-to-back -> word_cnt_o wraps to 0; throughput is 5 cycles per word with BEATS=4.
